// File: rtl/load_use_stall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_use_stall_unit: load-use / memory-busy stall and flush controller   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_use_stall_unit #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int COUNT_WIDTH       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             rs1_address_id_stage,
   input  logic [4:0]             rs2_address_id_stage,
   input  logic                   rs1_used,
   input  logic                   rs2_used,
   input  logic [4:0]             destination_address,
   input  logic                   mem_read_alu_stage,
   input  logic                   branch_taken,
   input  logic                   mem_busy,
   output logic                   pc_write_enable,
   output logic                   if_id_write_enable,
   output logic                   if_id_flush,
   output logic                   id_alu_bubble,
   output logic                   pipeline_hold,
   output logic [COUNT_WIDTH-1:0] stall_count
);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } state_t;

   localparam logic [3:0] c_REMAIN_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
   localparam bit         c_MULTI_CYCLE   = (LOAD_STALL_CYCLES > 1);

   state_t                 r_state;
   state_t                 r_resume;
   logic [3:0]             r_remain;
   logic [COUNT_WIDTH-1:0] r_stall_count;

   state_t     w_state_next;
   state_t     w_resume_next;
   state_t     w_mode;
   logic [3:0] w_remain_next;
   logic       w_hazard;
   logic       w_pc_we;
   logic       w_if_id_we;
   logic       w_flush;
   logic       w_bubble;
   logic       w_hold;

   assign w_hazard = mem_read_alu_stage && (destination_address != 5'd0) &&
                     ((rs1_used && (rs1_address_id_stage == destination_address)) ||
                      (rs2_used && (rs2_address_id_stage == destination_address)));

   // MEM_WAIT behaves exactly like the state it interrupted once memory is ready.
   assign w_mode = (r_state == ST_MEM_WAIT) ? r_resume : r_state;

   always_comb begin
      w_pc_we       = 1'b1;
      w_if_id_we    = 1'b1;
      w_flush       = 1'b0;
      w_bubble      = 1'b0;
      w_hold        = 1'b0;
      w_state_next  = r_state;
      w_resume_next = r_resume;
      w_remain_next = r_remain;
      if (reset) begin
         if (mem_busy) begin
            w_pc_we       = 1'b0;
            w_if_id_we    = 1'b0;
            w_hold        = 1'b1;
            w_state_next  = ST_MEM_WAIT;
            w_resume_next = w_mode;
         end else if (branch_taken) begin
            w_flush       = 1'b1;
            w_bubble      = 1'b1;
            w_state_next  = ST_RUN;
            w_remain_next = 4'd0;
         end else if (w_mode == ST_LOAD_STALL) begin
            w_pc_we    = 1'b0;
            w_if_id_we = 1'b0;
            w_bubble   = 1'b1;
            if (r_remain == 4'd1) begin
               w_state_next  = ST_RUN;
               w_remain_next = 4'd0;
            end else begin
               w_state_next  = ST_LOAD_STALL;
               w_remain_next = r_remain - 4'd1;
            end
         end else begin
            w_state_next = ST_RUN;
            if (w_hazard) begin
               w_pc_we    = 1'b0;
               w_if_id_we = 1'b0;
               w_bubble   = 1'b1;
               if (c_MULTI_CYCLE) begin
                  w_state_next  = ST_LOAD_STALL;
                  w_remain_next = c_REMAIN_RELOAD;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_RUN;
         r_resume      <= ST_RUN;
         r_remain      <= 4'd0;
         r_stall_count <= '0;
      end else begin
         r_state  <= w_state_next;
         r_resume <= w_resume_next;
         r_remain <= w_remain_next;
         if (!w_pc_we && (r_stall_count != {COUNT_WIDTH{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign pc_write_enable    = w_pc_we;
   assign if_id_write_enable = w_if_id_we;
   assign if_id_flush        = w_flush;
   assign id_alu_bubble      = w_bubble;
   assign pipeline_hold      = w_hold;
   assign stall_count        = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_load_use_stall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_load_use_stall_unit: scoreboard bench over four parameterisations     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_load_use_stall_unit;

   localparam int c_NDUT = 4;
   localparam int c_NS[c_NDUT] = '{1, 3, 3, 15};
   localparam int c_WS[c_NDUT] = '{16, 16, 4, 16};

   typedef struct packed {
      logic        pc;
      logic        ifid;
      logic        flush;
      logic        bubble;
      logic        hold;
      logic [15:0] cnt;
   } exp_t;
   typedef exp_t [c_NDUT-1:0] exp_vec_t;

   logic       clk;
   logic       reset;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, mr, br, busy;

   exp_vec_t   act;
   exp_vec_t   q[$];
   int         vectors;
   int         errors;
   int         left[c_NDUT];
   int         cnt[c_NDUT];

   for (genvar g = 0; g < c_NDUT; g++) begin : g_duts
      logic pc, ifid, flush, bubble, hold;
      logic [c_WS[g]-1:0] sc;
      load_use_stall_unit #(
         .LOAD_STALL_CYCLES(c_NS[g]),
         .COUNT_WIDTH      (c_WS[g])
      ) u_dut (
         .clk                 (clk),
         .reset               (reset),
         .rs1_address_id_stage(rs1),
         .rs2_address_id_stage(rs2),
         .rs1_used            (u1),
         .rs2_used            (u2),
         .destination_address (rd),
         .mem_read_alu_stage  (mr),
         .branch_taken        (br),
         .mem_busy            (busy),
         .pc_write_enable     (pc),
         .if_id_write_enable  (ifid),
         .if_id_flush         (flush),
         .id_alu_bubble       (bubble),
         .pipeline_hold       (hold),
         .stall_count         (sc)
      );
      assign act[g] = {pc, ifid, flush, bubble, hold, 16'(sc)};
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic compare(input int idx, input exp_t a, input exp_t e, input string name);
      vectors++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s dut%0d: got pc=%b ifid=%b flush=%b bub=%b hold=%b cnt=%0d, want pc=%b ifid=%b flush=%b bub=%b hold=%b cnt=%0d",
                  name, idx, a.pc, a.ifid, a.flush, a.bubble, a.hold, a.cnt,
                  e.pc, e.ifid, e.flush, e.bubble, e.hold, e.cnt);
      end
   endtask

   // Monitor: outputs settle mid-cycle, so compare on the falling edge.
   initial begin
      exp_vec_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < c_NDUT; i++) compare(i, act[i], e[i], "cycle");
         end
      end
   end

   // Reference model: each DUT owes `left` more stall cycles; memory busy
   // freezes that debt, a taken branch cancels it.
   task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic e1,
                        input logic e2, input logic [4:0] d, input logic ld,
                        input logic b, input logic mb);
      exp_vec_t ev;
      logic     hz;
      @(posedge clk);
      #1;
      rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; mr = ld; br = b; busy = mb;
      hz = ld && (d != 0) && ((e1 && a1 == d) || (e2 && a2 == d));
      for (int i = 0; i < c_NDUT; i++) begin
         ev[i] = '{pc: 1'b1, ifid: 1'b1, flush: 1'b0, bubble: 1'b0, hold: 1'b0,
                   cnt: 16'(cnt[i])};
         if (mb) begin
            ev[i].pc = 1'b0; ev[i].ifid = 1'b0; ev[i].hold = 1'b1;
         end else if (b) begin
            ev[i].flush = 1'b1; ev[i].bubble = 1'b1; left[i] = 0;
         end else if (left[i] > 0) begin
            ev[i].pc = 1'b0; ev[i].ifid = 1'b0; ev[i].bubble = 1'b1; left[i]--;
         end else if (hz) begin
            ev[i].pc = 1'b0; ev[i].ifid = 1'b0; ev[i].bubble = 1'b1;
            left[i] = c_NS[i] - 1;
         end
         if (!ev[i].pc && cnt[i] < (1 << c_WS[i]) - 1) cnt[i]++;
      end
      q.push_back(ev);
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_inputs_hazard();
      rs1 = 5'd9; rs2 = 5'd0; u1 = 1'b1; u2 = 1'b0; rd = 5'd9; mr = 1'b1; br = 1'b0; busy = 1'b0;
   endtask

   task automatic set_inputs_idle();
      rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0; rd = 5'd0; mr = 1'b0; br = 1'b0; busy = 1'b0;
   endtask

   task automatic check_defaults(input string name);
      exp_t d;
      d = '{pc: 1'b1, ifid: 1'b1, flush: 1'b0, bubble: 1'b0, hold: 1'b0, cnt: 16'd0};
      for (int i = 0; i < c_NDUT; i++) compare(i, act[i], d, name);
   endtask

   task automatic model_reset();
      for (int i = 0; i < c_NDUT; i++) begin
         left[i] = 0;
         cnt[i]  = 0;
      end
   endtask

   // Pull reset low between edges while a hazard is still presented.
   task automatic reset_mid();
      @(posedge clk);
      #1;
      set_inputs_hazard();
      #3;
      reset = 1'b0;
      #1;
      check_defaults("async_reset");
      set_inputs_idle();
      #2;
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      model_reset();
      reset = 1'b0;
      set_inputs_hazard();
      #3;
      check_defaults("reset_state");
      set_inputs_idle();
      #9;
      reset = 1'b1;

      // Single load-use hazard on rs1
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      repeat (16) idle();
      // x0 destination and unused operand never stall
      drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      drive(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      // Hazard on rs2, then memory busy for two cycles in the second stall cycle
      drive(5'd1, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      repeat (16) idle();
      // Taken branch in the second stall cycle aborts the stall
      drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      repeat (3) idle();
      // Long busy run drives the narrow counter into saturation
      repeat (20) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      repeat (2) idle();
      // Reset while a multi-cycle stall is in progress, then normal detection
      drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
      reset_mid();
      drive(5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
      repeat (16) idle();

      // Randomized traffic over a small register window to make hazards common
      for (int n = 0; n < 600; n++) begin
         drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 60),
               1'($urandom_range(0, 99) < 8), 1'($urandom_range(0, 99) < 12));
         if (n == 300) reset_mid();
      end
      repeat (3) idle();

      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
